// File: rtl/note_sequencer.sv
// note_sequencer: walks a song ROM one note record at a time and drives the
// tone datapath (pitch, octave, enable). Each note is timed in milliseconds
// from the system clock. A fixed articulation gap is carved from the tail of
// each note. Rests, a zero-duration no-op, an end marker with optional loop,
// and play/pause/stop control are supported. All outputs are registered.
module note_sequencer #(
    parameter int CLK_HZ = 27000000,
    parameter int ID_W   = 10,
    parameter int GAP_MS = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic            pause,
    input  logic            loop_en,
    output logic [ID_W-1:0] rom_addr,
    input  logic [6:0]      rom_pitch,
    input  logic [14:0]     rom_dur_ms,
    input  logic [4:0]      rom_octave,
    output logic [6:0]      tone_pitch,
    output logic [4:0]      tone_octave,
    output logic            tone_en,
    output logic            busy,
    output logic            song_done
);

    localparam int TICKS_PER_MS = CLK_HZ / 1000;
    localparam int PS_W         = $clog2(TICKS_PER_MS);
    localparam logic [6:0] PITCH_REST = 7'd12;
    localparam logic [6:0] PITCH_END  = 7'd13;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;

    state_t            state, state_nx;
    logic [PS_W-1:0]   ps, ps_nx;
    logic [14:0]       ms_left, ms_left_nx;
    logic [14:0]       gap_ms, gap_nx;       // ms of silence at the tail of the current note
    logic [ID_W-1:0]   rom_addr_nx;
    logic [6:0]        tone_pitch_nx;
    logic [4:0]        tone_octave_nx;
    logic              tone_en_nx, busy_nx, song_done_nx;

    logic              run, ms_tick, play_done, gap_done, is_end, is_zero;
    logic [14:0]       ms_dec;

    // Timing qualifiers: counting only happens in PLAY/GAP while not paused.
    always_comb begin
        run       = ((state == PLAY) || (state == GAP)) && !pause;
        ms_tick   = (ps == PS_W'(TICKS_PER_MS - 1));
        ms_dec    = ms_left - 15'd1;
        play_done = (state == PLAY) && run && ms_tick && (ms_dec == gap_ms);
        gap_done  = (state == GAP) && run && ms_tick && (ms_left == 15'd1);
        is_end    = (rom_pitch >= PITCH_END);
        is_zero   = (rom_dur_ms == 15'd0);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode; stop beats start, start restarts from any state.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = IDLE;
            FETCH: state_nx = LOAD;
            LOAD: begin
                if (is_end)       state_nx = loop_en ? FETCH : IDLE;
                else if (is_zero) state_nx = FETCH;
                else              state_nx = PLAY;
            end
            PLAY:    if (play_done) state_nx = (gap_ms == 15'd0) ? FETCH : GAP;
            GAP:     if (gap_done)  state_nx = FETCH;
            default: state_nx = IDLE;
        endcase
        if (start) state_nx = FETCH;
        if (stop)  state_nx = IDLE;
    end

    // Next values of the datapath registers and the registered outputs.
    always_comb begin
        rom_addr_nx    = rom_addr;
        ps_nx          = ps;
        ms_left_nx     = ms_left;
        gap_nx         = gap_ms;
        tone_pitch_nx  = tone_pitch;
        tone_octave_nx = tone_octave;
        song_done_nx   = 1'b0;
        case (state)
            LOAD: begin
                if (is_end) begin
                    rom_addr_nx  = '0;
                    song_done_nx = !loop_en;
                end else if (is_zero) begin
                    rom_addr_nx = rom_addr + ID_W'(1);
                end else begin
                    tone_pitch_nx  = rom_pitch;
                    tone_octave_nx = rom_octave;
                    ms_left_nx     = rom_dur_ms;
                    ps_nx          = '0;
                    // Notes no longer than the gap play in full with no gap.
                    gap_nx = (rom_dur_ms > 15'(GAP_MS)) ? 15'(GAP_MS) : 15'd0;
                end
            end
            PLAY, GAP: begin
                if (run) begin
                    if (ms_tick) begin
                        ps_nx      = '0;
                        ms_left_nx = ms_dec;
                    end else begin
                        ps_nx = ps + PS_W'(1);
                    end
                    // Natural wrap of the address width gives modulo advance.
                    if ((play_done && gap_ms == 15'd0) || gap_done)
                        rom_addr_nx = rom_addr + ID_W'(1);
                end
            end
            default: ;
        endcase
        if (start || stop) begin
            rom_addr_nx  = '0;
            song_done_nx = 1'b0;
        end
        tone_en_nx = (state_nx == PLAY) && !pause && (tone_pitch_nx != PITCH_REST);
        busy_nx    = (state_nx != IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr    <= '0;
            ps          <= '0;
            ms_left     <= '0;
            gap_ms      <= '0;
            tone_pitch  <= '0;
            tone_octave <= '0;
            tone_en     <= 1'b0;
            busy        <= 1'b0;
            song_done   <= 1'b0;
        end else begin
            rom_addr    <= rom_addr_nx;
            ps          <= ps_nx;
            ms_left     <= ms_left_nx;
            gap_ms      <= gap_nx;
            tone_pitch  <= tone_pitch_nx;
            tone_octave <= tone_octave_nx;
            tone_en     <= tone_en_nx;
            busy        <= busy_nx;
            song_done   <= song_done_nx;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a small 4-entry synchronous song ROM, a
// note-level reference model that expands the song into the expected
// per-cycle output trace, and scenario tasks comparing observed traces.
module tb_note_sequencer;

    localparam int T   = 4;   // ticks per ms at CLK_HZ=4000
    localparam int GAP = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
    logic [1:0]  rom_addr;
    logic [6:0]  rom_pitch;
    logic [14:0] rom_dur_ms;
    logic [4:0]  rom_octave;
    logic [6:0]  tone_pitch;
    logic [4:0]  tone_octave;
    logic        tone_en, busy, song_done;

    note_sequencer #(.CLK_HZ(4000), .ID_W(2), .GAP_MS(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .rom_addr(rom_addr), .rom_pitch(rom_pitch),
        .rom_dur_ms(rom_dur_ms), .rom_octave(rom_octave),
        .tone_pitch(tone_pitch), .tone_octave(tone_octave),
        .tone_en(tone_en), .busy(busy), .song_done(song_done)
    );

    always #5 clk = ~clk;

    // Song ROM with one cycle of read latency.
    logic [6:0]  rp [4];
    logic [14:0] rd [4];
    logic [4:0]  ro [4];
    always @(posedge clk) begin
        rom_pitch  <= rp[rom_addr];
        rom_dur_ms <= rd[rom_addr];
        rom_octave <= ro[rom_addr];
    end

    // Row layout: {tone_en, busy, song_done, rom_addr, tone_pitch, tone_octave}
    typedef logic [16:0] row_t;
    row_t exp_q[$];
    row_t obs_q[$];
    bit   ph_q[$];     // 1 = row lies in the timed (PLAY/GAP) part of a note
    int   checks = 0;
    int   failures = 0;

    function automatic row_t mk(bit en, bit b, bit d, int a, logic [6:0] p, logic [4:0] o);
        return {en, b, d, 2'(a), p, o};
    endfunction

    // Reference model: expand the ROM song into the expected output trace.
    task automatic build_trace(input bit lp, input int maxlen, input logic [6:0] p0, input logic [4:0] o0);
        int a, g, pl;
        logic [6:0] cp;
        logic [4:0] co;
        exp_q.delete(); ph_q.delete();
        a = 0; cp = p0; co = o0;
        while (exp_q.size() < maxlen) begin
            repeat (2) begin exp_q.push_back(mk(0, 1, 0, a, cp, co)); ph_q.push_back(0); end
            if (rp[a] >= 13) begin
                if (lp) begin a = 0; continue; end
                exp_q.push_back(mk(0, 0, 1, 0, cp, co)); ph_q.push_back(0);
                while (exp_q.size() < maxlen) begin
                    exp_q.push_back(mk(0, 0, 0, 0, cp, co)); ph_q.push_back(0);
                end
            end else if (rd[a] == 0) begin
                a = (a + 1) % 4;
            end else begin
                cp = rp[a]; co = ro[a];
                g  = (rd[a] > GAP) ? GAP : 0;
                pl = int'(rd[a]) - g;
                repeat (pl * T) begin exp_q.push_back(mk(cp != 12, 1, 0, a, cp, co)); ph_q.push_back(1); end
                repeat (g * T)  begin exp_q.push_back(mk(0, 1, 0, a, cp, co)); ph_q.push_back(1); end
                a = (a + 1) % 4;
            end
        end
        while (exp_q.size() > maxlen) begin void'(exp_q.pop_back()); void'(ph_q.pop_back()); end
    endtask

    // A pause of plen cycles after row prow freezes the note and silences it.
    task automatic insert_pause(input int prow, input int plen, input int maxlen);
        row_t r;
        r = exp_q[prow];
        r[16] = 1'b0;
        repeat (plen) begin exp_q.insert(prow + 1, r); ph_q.insert(prow + 1, 1); end
        while (exp_q.size() > maxlen) begin void'(exp_q.pop_back()); void'(ph_q.pop_back()); end
    endtask

    // Pulse start and record n output rows, optionally holding pause.
    task automatic collect(input int n, input int prow, input int plen);
        obs_q.delete();
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < n; k++) begin
            obs_q.push_back({tone_en, busy, song_done, rom_addr, tone_pitch, tone_octave});
            pause = (prow >= 0) && (k >= prow) && (k < prow + plen);
            @(negedge clk);
        end
        pause = 1'b0;
    endtask

    task automatic do_reset();
        start = 0; stop = 0; pause = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_song();
        rp[0] = 7'd0;  rd[0] = 15'd3; ro[0] = 5'd4;
        rp[1] = 7'd3;  rd[1] = 15'd2; ro[1] = 5'd5;
        rp[2] = 7'd20; rd[2] = 15'd0; ro[2] = 5'd0;
        rp[3] = 7'd1;  rd[3] = 15'd1; ro[3] = 5'd1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({tone_en, busy, song_done, rom_addr, tone_pitch, tone_octave} !== 17'd0) begin
            failures++;
            $display("FAIL reset_hold: got %h want 0", {tone_en, busy, song_done, rom_addr, tone_pitch, tone_octave});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tone_en, busy, song_done, rom_addr} !== 5'd0) begin
            failures++;
            $display("FAIL idle_after_reset: got %h want 0", {tone_en, busy, song_done, rom_addr});
        end
    endtask

    task automatic test_song_once();
        do_reset(); load_song(); loop_en = 0;
        build_trace(0, 40, 7'd0, 5'd0);
        collect(exp_q.size(), -1, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL song_once row %0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_loop_stop();
        do_reset(); load_song(); loop_en = 1;
        build_trace(1, 60, 7'd0, 5'd0);
        collect(exp_q.size(), -1, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL loop row %0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        checks++;
        if ({tone_en, busy, song_done, rom_addr} !== 5'd0) begin
            failures++;
            $display("FAIL loop_stop: got %h want 0", {tone_en, busy, song_done, rom_addr});
        end
        loop_en = 0;
    endtask

    task automatic test_rest_zero();
        do_reset();
        rp[0] = 7'd12; rd[0] = 15'd2; ro[0] = 5'd2;
        rp[1] = 7'd5;  rd[1] = 15'd0; ro[1] = 5'd6;
        rp[2] = 7'd2;  rd[2] = 15'd1; ro[2] = 5'd3;
        rp[3] = 7'd127; rd[3] = 15'd9; ro[3] = 5'd0;
        loop_en = 0;
        build_trace(0, 24, 7'd0, 5'd0);
        collect(exp_q.size(), -1, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL rest_zero row %0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_pause();
        int done_at;
        do_reset(); load_song(); rp[1] = 7'd99; loop_en = 0;
        build_trace(0, 32, 7'd0, 5'd0);
        insert_pause(5, 7, 32);
        collect(exp_q.size(), 5, 7);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL pause row %0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        // fetch+load, 12 timed cycles stretched by 7 paused, fetch+load of end marker
        done_at = -1;
        for (int k = 0; k < obs_q.size(); k++) if (obs_q[k][14] && done_at < 0) done_at = k;
        checks++;
        if (done_at !== 23) begin
            failures++;
            $display("FAIL pause_length: song_done at row %0d want 23", done_at);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(); load_song(); loop_en = 0;
        collect(6, -1, 0);
        start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        checks++;
        if ({tone_en, busy, song_done, rom_addr} !== 5'd0) begin
            failures++;
            $display("FAIL start_stop: got %h want 0", {tone_en, busy, song_done, rom_addr});
        end
        // lone start, then a restart during PLAY of note 1 (row 18)
        build_trace(0, 18, 7'd0, 5'd4);
        collect(18, -1, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL first_run row %0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        build_trace(0, 30, 7'd3, 5'd5);
        collect(exp_q.size(), -1, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL restart row %0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_wrap_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rp[i] = 7'(i + 4); rd[i] = 15'd1; ro[i] = 5'(i + 1);
        end
        loop_en = 0;
        build_trace(0, 40, 7'd0, 5'd0);
        collect(exp_q.size(), -1, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL wrap row %0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        // mid-PLAY: drop reset between edges and look before any posedge
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tone_en, busy, song_done, rom_addr, tone_pitch, tone_octave} !== 17'd0) begin
            failures++;
            $display("FAIL async_reset: got %h want 0", {tone_en, busy, song_done, rom_addr, tone_pitch, tone_octave});
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        int prow, plen;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            for (int i = 0; i < 4; i++) begin
                rp[i] = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(13, 127)) : 7'($urandom_range(0, 12));
                rd[i] = 15'($urandom_range(0, 3));
                ro[i] = 5'($urandom_range(0, 31));
            end
            loop_en = 1'($urandom_range(0, 1));
            build_trace(loop_en, 60, 7'd0, 5'd0);
            prow = $urandom_range(2, 40);
            plen = $urandom_range(1, 6);
            if (ph_q[prow]) insert_pause(prow, plen, 60);
            else prow = -1;
            collect(exp_q.size(), prow, plen);
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    failures++;
                    $display("FAIL random%0d row %0d: got %h want %h", it, k, obs_q[k], exp_q[k]);
                end
            end
            stop = 1'b1;
            @(negedge clk); stop = 1'b0;
        end
    endtask

    initial begin
        load_song();
        test_reset();
        test_song_once();
        test_loop_stop();
        test_rest_zero();
        test_pause();
        test_back_to_back();
        test_wrap_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Sequences a song ROM into the pitch/octave/enable controls of the square-wave tone datapath. It fetches one note record per note_id, times its duration in milliseconds from the system clock, and inserts a fixed articulation gap between notes. It also handles rests, an end-of-song marker, looping and play/pause/stop control. It sits between the song ROM and the pitch-to-divider/speaker-toggle logic, replacing free-running note counting with an explicit FSM.

## Interface
- CLK_HZ, 27000000, system clock frequency; TICKS_PER_MS = CLK_HZ/1000 (integer, ≥2)
- ID_W, 10, note_id / ROM address width
- GAP_MS, 10, silent gap inserted at the end of each note
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse: (re)start playback from note 0
- stop  in  1  pulse: abort playback, return to idle
- pause  in  1  level: freeze timing and silence output while high
- loop_en  in  1  on end marker: 1 = restart at note 0, 0 = finish
- rom_addr  out  ID_W  note_id presented to song ROM (registered)
- rom_pitch  in  7  0–11 semitone (A..G#), 12 = rest, 13–127 = end-of-song
- rom_dur_ms  in  15  note duration in ms
- rom_octave  in  5  octave
- tone_pitch  out  7  latched pitch to the divider datapath
- tone_octave  out  5  latched octave
- tone_en  out  1  1 = speaker toggling allowed
- busy  out  1  high in any state except IDLE
- song_done  out  1  one-cycle pulse when a non-looping song ends

## Operation
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE: tone_en=0, rom_addr=0. On start → FETCH.
- FETCH: rom_addr stable for one cycle, allowing a 1-cycle synchronous ROM. Always → LOAD.
- LOAD: capture rom_pitch/rom_dur_ms/rom_octave, then decode:
  - pitch ≥13: if loop_en=1, rom_addr←0 → FETCH; else song_done=1 → IDLE.
  - dur_ms=0: no-op; rom_addr←rom_addr+1 → FETCH.
  - otherwise: tone_pitch/tone_octave←captured values; ms_left←dur_ms; prescaler←0. If dur_ms>GAP_MS, play_ms←dur_ms−GAP_MS, else play_ms←dur_ms (no gap) → PLAY.
- PLAY: tone_en=1 unless pitch=12 (rest) or pause=1. Prescaler counts 0..TICKS_PER_MS−1; at terminal count, ms_left decrements. When ms_left reaches dur_ms−play_ms: if ms_left=0 → advance, else → GAP.
- GAP: tone_en=0; continue counting ms until ms_left=0 → advance.
- Advance: rom_addr←rom_addr+1 modulo 2^ID_W, so all-ones wraps to 0 → FETCH.
- pause=1 in PLAY/GAP: prescaler, ms_left and state hold; tone_en=0. Resumes the exact remaining count on release. pause is ignored in IDLE/FETCH/LOAD.
- stop in any state → IDLE, rom_addr←0. Stop has priority over start in the same cycle.
- start while busy → FETCH with rom_addr←0 (restart), unless stop is also asserted.
- ms_left is 15 bits; arithmetic is unsigned with no saturation needed, since play_ms ≤ dur_ms.

## Timing
- Reset values: rom_addr=0, tone_pitch=0, tone_octave=0, tone_en=0, busy=0, song_done=0, state IDLE, counters 0.
- All outputs are registered; tone_en asserts the cycle after LOAD→PLAY.
- Per sounding note: FETCH 1 + LOAD 1 + dur_ms×TICKS_PER_MS cycles in PLAY+GAP.
- tone_en high for play_ms×TICKS_PER_MS cycles, then low for (dur_ms−play_ms)×TICKS_PER_MS cycles.
- start→first tone_en: 3 cycles (FETCH, LOAD, then PLAY output).
- stop→tone_en=0 and busy=0: next edge.
- song_done: asserted in the cycle after LOAD sees the end marker, coincident with busy falling.
- Pause adds exactly the number of paused cycles to the note length.

## Test plan
- CLK_HZ=4000 (TICKS=4), GAP_MS=1; ROM {A,o4,3ms},{C,o5,2ms},{end}; start, loop_en=0 → tone_en high 8, low 4, high 4, low 4 cycles, with 2-cycle fetch gaps; song_done pulses once; busy falls; tone_pitch sequence 0,3.
- Same ROM, loop_en=1 → rom_addr sequence 0,1,2,0,1,…; song_done never asserts; stop then clears busy next edge.
- ROM {rest,2ms},{dur 0},{B,1ms},{end} → tone_en low 8 cycles; note 1 consumes only FETCH+LOAD; B plays 4 cycles with no gap (dur ≤ GAP_MS).
- pause high for 7 cycles mid-PLAY of a 3ms note → tone_en low during pause; total note length 12+7 cycles.
- Simultaneous start+stop during PLAY → IDLE, rom_addr=0; a later lone start during PLAY of note 1 → restart at addr 0 in 1 cycle.
- ID_W=2, ROM with no end marker → rom_addr wraps 3→0; async rst_n low mid-PLAY → all outputs at reset values immediately, without waiting for a clock edge.
